// File: rtl/k423_id_issue_ctrl.sv
// rtl/k423_id_issue_ctrl.sv - id-to-ex issue controller with register scoreboard
//
// Purpose: Tracks in-flight destination registers, stalls RAW/WAW hazards,
//          bounds outstanding instructions and serializes CSR/exception
//          instructions. Owns the id->ex valid/ready handshake.
// Optional feature macro: K423_ISSUE_WB_BYPASS_EN (hazard check ignores a
//          pending bit being cleared by writeback in the same cycle).
// Ports:
//   clk_i, rst_n_i                     clock, async active-low reset
//   id_vld_i / id_rdy_o                decoded instruction handshake
//   dec_grp_i, dec_excp_flag_i         group one-hot, exception flag
//   dec_rs1/rs2/rd_vld_i, *_idx_i      operand valid flags and indices
//   ex_vld_o / ex_rdy_i                issue handshake to ex stage
//   wb_vld_i, wb_rd_idx_i              register writeback
//   retire_i                           one instruction retired
//   flush_i                            pipeline flush
//   busy_o                             outstanding work or not in RUN
module k423_id_issue_ctrl #(
  parameter int MAX_OUTST     = 4,
  parameter int INST_GRP_W    = 5,
  parameter int INST_GRP_CSR  = 4,
  parameter int INST_RSDIDX_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     id_vld_i,
  output logic                     id_rdy_o,
  input  logic [INST_GRP_W-1:0]    dec_grp_i,
  input  logic                     dec_excp_flag_i,
  input  logic                     dec_rs1_vld_i,
  input  logic                     dec_rs2_vld_i,
  input  logic                     dec_rd_vld_i,
  input  logic [INST_RSDIDX_W-1:0] dec_rs1_idx_i,
  input  logic [INST_RSDIDX_W-1:0] dec_rs2_idx_i,
  input  logic [INST_RSDIDX_W-1:0] dec_rd_idx_i,
  output logic                     ex_vld_o,
  input  logic                     ex_rdy_i,
  input  logic                     wb_vld_i,
  input  logic [INST_RSDIDX_W-1:0] wb_rd_idx_i,
  input  logic                     retire_i,
  input  logic                     flush_i,
  output logic                     busy_o
);

  localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] wb_clear;
  logic [31:0] pend_chk;
  logic        hazard;
  logic        cnt_zero;
  logic        full;
  logic        serial;
  logic        offer;
  logic        fire;
  logic        unused_grp;

  // Only the CSR bit of the group vector matters here.
  assign unused_grp = ^dec_grp_i;

  always_comb begin
    wb_clear = '0;
    if (wb_vld_i) wb_clear[wb_rd_idx_i] = 1'b1;
`ifdef K423_ISSUE_WB_BYPASS_EN
    // Regfile writes through, so a register retiring this cycle is readable now.
    pend_chk = pend_q & ~wb_clear;
`else
    pend_chk = pend_q;
`endif
  end

  assign hazard   = (dec_rs1_vld_i & pend_chk[dec_rs1_idx_i]) |
                    (dec_rs2_vld_i & pend_chk[dec_rs2_idx_i]) |
                    (dec_rd_vld_i  & pend_chk[dec_rd_idx_i]);
  assign cnt_zero = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign serial   = dec_grp_i[INST_GRP_CSR] | dec_excp_flag_i;

  always_comb begin
    state_d = state_q;
    offer   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (id_vld_i) begin
          if (!serial)        offer   = ~hazard & ~full;
          else if (!cnt_zero) state_d = ST_DRAIN;
          else                offer   = ~hazard;
        end
      end
      // cnt==0 implies not full, so only the hazard gates the held instruction.
      ST_DRAIN:  offer = cnt_zero & ~hazard;
      ST_SERIAL: if (cnt_zero) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    // Gated by reset so nothing is offered while the core is held in reset.
    ex_vld_o = rst_n_i & ~flush_i & id_vld_i & offer;
    fire     = ex_vld_o & ex_rdy_i;
    id_rdy_o = fire;

    if (fire && serial) state_d = ST_SERIAL;

    cnt_d = cnt_q;
    unique case ({fire, retire_i & ~cnt_zero})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // Clear first, then set, so a same-index set in the same cycle wins.
    pend_d = pend_q & ~wb_clear;
    if (fire && dec_rd_vld_i && (dec_rd_idx_i != '0)) pend_d[dec_rd_idx_i] = 1'b1;
    pend_d[0] = 1'b0;

    if (flush_i) begin
      pend_d  = '0;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = ~cnt_zero | (state_q != ST_RUN);

endmodule

// File: tb/tb_k423_id_issue_ctrl.sv
// tb/tb_k423_id_issue_ctrl.sv - directed self-checking bench for k423_id_issue_ctrl
module tb_k423_id_issue_ctrl;

  localparam logic [4:0] G_ALU = 5'b00001;
  localparam logic [4:0] G_CSR = 5'b10000;
`ifdef K423_ISSUE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk, rst_n;
  logic       id_vld, id_rdy;
  logic [4:0] dec_grp;
  logic       dec_excp;
  logic       rs1_vld, rs2_vld, rd_vld;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;
  logic       ex_vld, ex_rdy;
  logic       wb_vld;
  logic [4:0] wb_rd_idx;
  logic       retire, flush, busy;

  int compared   = 0;
  int mismatched = 0;

  k423_id_issue_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_vld_i(id_vld), .id_rdy_o(id_rdy),
    .dec_grp_i(dec_grp), .dec_excp_flag_i(dec_excp),
    .dec_rs1_vld_i(rs1_vld), .dec_rs2_vld_i(rs2_vld), .dec_rd_vld_i(rd_vld),
    .dec_rs1_idx_i(rs1_idx), .dec_rs2_idx_i(rs2_idx), .dec_rd_idx_i(rd_idx),
    .ex_vld_o(ex_vld), .ex_rdy_i(ex_rdy),
    .wb_vld_i(wb_vld), .wb_rd_idx_i(wb_rd_idx),
    .retire_i(retire), .flush_i(flush), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [4:0] grp, input logic ex,
                          input logic r1v, input logic [4:0] r1,
                          input logic r2v, input logic [4:0] r2,
                          input logic rdv, input logic [4:0] rd);
    dec_grp = grp; dec_excp = ex;
    rs1_vld = r1v; rs1_idx = r1;
    rs2_vld = r2v; rs2_idx = r2;
    rd_vld  = rdv; rd_idx  = rd;
    id_vld  = 1'b1;
  endtask

  task automatic do_flush();
    id_vld = 1'b0; retire = 1'b0; wb_vld = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc(); cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL reset_ex_vld: got %b want 0", ex_vld); end
    compared++; if (id_rdy !== 1'b0) begin mismatched++; $display("FAIL reset_id_rdy: got %b want 0", id_rdy); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    #1;
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL post_reset_ex_vld: got %b want 1", ex_vld); end
    compared++; if (id_rdy !== 1'b1) begin mismatched++; $display("FAIL post_reset_id_rdy: got %b want 1", id_rdy); end
    id_vld = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_flush();
    ex_rdy = 1'b0;
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL b2b_not_ready_vld: got %b want 1", ex_vld); end
    compared++; if (id_rdy !== 1'b0) begin mismatched++; $display("FAIL b2b_not_ready_rdy: got %b want 0", id_rdy); end
    cyc();
    ex_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(10 + i));
      @(negedge clk);
      compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL b2b_fire%0d: got %b want 1", i, ex_vld); end
      cyc();
    end
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd14);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL b2b_full_hold: got %b want 0", ex_vld); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_full_busy: got %b want 1", busy); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL b2b_full_hold2: got %b want 0", ex_vld); end
    retire = 1'b1;
    #1;
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL b2b_retire_cycle: got %b want 0", ex_vld); end
    cyc();
    retire = 1'b0;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL b2b_after_retire_vld: got %b want 1", ex_vld); end
    compared++; if (id_rdy !== 1'b1) begin mismatched++; $display("FAIL b2b_after_retire_rdy: got %b want 1", id_rdy); end
    cyc();
    do_flush();
  endtask

  task automatic test_raw();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL raw_producer: got %b want 1", ex_vld); end
    cyc();
    set_inst(G_ALU, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL raw_stall1: got %b want 0", ex_vld); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL raw_stall2: got %b want 0", ex_vld); end
    wb_vld = 1'b1; wb_rd_idx = 5'd5;
    #1;
    compared++; if (ex_vld !== BYP) begin mismatched++; $display("FAIL raw_wb_cycle: got %b want %b", ex_vld, BYP); end
    cyc();
    wb_vld = 1'b0;
    @(negedge clk);
    compared++; if (ex_vld !== ~BYP) begin mismatched++; $display("FAIL raw_after_wb: got %b want %b", ex_vld, ~BYP); end
    do_flush();
  endtask

  task automatic test_x0();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL x0_write: got %b want 1", ex_vld); end
    cyc();
    set_inst(G_ALU, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL x0_reader1: got %b want 1", ex_vld); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL x0_reader2: got %b want 1", ex_vld); end
    do_flush();
  endtask

  task automatic test_set_wins();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    wb_vld = 1'b1; wb_rd_idx = 5'd7;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL setwin_fire: got %b want 1", ex_vld); end
    cyc();
    wb_vld = 1'b0;
    set_inst(G_ALU, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL setwin_reader1: got %b want 0", ex_vld); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL setwin_reader2: got %b want 0", ex_vld); end
    do_flush();
  endtask

  task automatic test_csr();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc(); cyc();
    set_inst(G_CSR, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL csr_run_hold: got %b want 0", ex_vld); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL csr_busy: got %b want 1", busy); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL csr_drain_cnt2: got %b want 0", ex_vld); end
    retire = 1'b1;
    cyc();
    retire = 1'b0;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL csr_drain_cnt1: got %b want 0", ex_vld); end
    retire = 1'b1;
    cyc();
    retire = 1'b0;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL csr_drain_offer: got %b want 1", ex_vld); end
    cyc();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL csr_serial_hold: got %b want 0", ex_vld); end
    retire = 1'b1;
    cyc();
    retire = 1'b0;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL csr_serial_cnt0: got %b want 0", ex_vld); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL csr_serial_busy: got %b want 1", busy); end
    cyc();
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL csr_back_to_run: got %b want 1", ex_vld); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL csr_run_busy: got %b want 0", busy); end
    id_vld = 1'b0;
    cyc();
  endtask

  task automatic test_excp();
    do_flush();
    set_inst(G_ALU, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL excp_offer: got %b want 1", ex_vld); end
    cyc();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL excp_serial_hold: got %b want 0", ex_vld); end
    do_flush();
  endtask

  task automatic test_flush();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    cyc();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    cyc();
    id_vld = 1'b0;
    retire = 1'b1;
    cyc(); cyc();
    retire = 1'b0;
    set_inst(G_CSR, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL flush_csr_offer: got %b want 1", ex_vld); end
    cyc();
    set_inst(G_ALU, 1'b0, 1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL flush_serial_hold: got %b want 0", ex_vld); end
    flush = 1'b1; retire = 1'b1; wb_vld = 1'b1; wb_rd_idx = 5'd3;
    #1;
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL flush_cycle_vld: got %b want 0", ex_vld); end
    cyc();
    flush = 1'b0; retire = 1'b0; wb_vld = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL flush_busy: got %b want 0", busy); end
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL flush_pend_clear: got %b want 1", ex_vld); end
    flush = 1'b1;
    #1;
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL flush_run_vld: got %b want 0", ex_vld); end
    cyc();
    flush = 1'b0;
    id_vld = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    do_flush();
    set_inst(G_ALU, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc();
    set_inst(G_CSR, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL areset_pre_drain: got %b want 0", ex_vld); end
    cyc();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL areset_busy: got %b want 0", busy); end
    compared++; if (ex_vld !== 1'b0) begin mismatched++; $display("FAIL areset_vld: got %b want 0", ex_vld); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (ex_vld !== 1'b1) begin mismatched++; $display("FAIL areset_run_offer: got %b want 1", ex_vld); end
    id_vld = 1'b0;
    cyc();
  endtask

  initial begin
    id_vld = 1'b0; dec_grp = G_ALU; dec_excp = 1'b0;
    rs1_vld = 1'b0; rs2_vld = 1'b0; rd_vld = 1'b0;
    rs1_idx = '0; rs2_idx = '0; rd_idx = '0;
    ex_rdy = 1'b1; wb_vld = 1'b0; wb_rd_idx = '0;
    retire = 1'b0; flush = 1'b0; rst_n = 1'b0;

    test_reset();
    test_back_to_back();
    test_raw();
    test_x0();
    test_set_wins();
    test_csr();
    test_excp();
    test_flush();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
